// File: rtl/serial_adder_if.sv
// Bundles the request/result signals of the bit-serial adder.
// The requester drives operands and start; the adder returns busy/done and the result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: two half adders plus an OR form a full adder, and a carry
// flop chains the bits LSB-first, one bit per clock. The registered sum and
// carry-out are loaded on the last shift edge and announced with a one-cycle
// done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // The operand A register doubles as the result shift register: each new
    // sum bit enters at the MSB as the consumed operand bit leaves at the LSB.
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic s1, c1, s_bit, c2, carry_next, last_bit;
    logic busy_d, done_d;

    // Full adder out of two half-adder cells and an OR.
    assign s1         = a_sh_q[0] ^ b_sh_q[0];
    assign c1         = a_sh_q[0] & b_sh_q[0];
    assign s_bit      = s1 ^ carry_q;
    assign c2         = s1 & carry_q;
    assign carry_next = c1 | c2;
    assign last_bit   = (cnt_q == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy_d = 1'b1;
                if (last_bit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, one full-adder step per shift edge, and
    // load the visible result only on the final shift edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sh_q  <= bus.a;
                        b_sh_q  <= bus.b;
                        carry_q <= bus.cin;
                        cnt_q   <= '0;
                    end
                end
                ST_SHIFT: begin
                    a_sh_q  <= {s_bit, a_sh_q[WIDTH-1:1]};
                    b_sh_q  <= b_sh_q >> 1;
                    carry_q <= carry_next;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_bit) begin
                        sum_q  <= {s_bit, a_sh_q[WIDTH-1:1]};
                        cout_q <= carry_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = busy_d;
    assign bus.done = done_d;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance driven from a vector
// table plus reset/abort and ignored-start sequences, and a 2-bit instance
// swept exhaustively against a + b + cin.
module tb_serial_adder;
    logic clk;
    logic rst_n;

    int n_tests;
    int n_fail;

    logic [7:0] prev_sum;
    logic       prev_cout;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(2)) bus2 ();

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
        int         inject;   // shift edge after which a stray start is pulsed; 0 = none
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           input logic [7:0] es, input logic ec, input int inject);
        @(negedge clk);
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = cin;
        bus8.start = 1'b1;
        @(negedge clk);                       // just after accepting edge E0
        bus8.start = 1'b0;
        check("busy_after_accept", 32'(bus8.busy), 32'd1);
        check("done_after_accept", 32'(bus8.done), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);                   // just after shift edge Ek
            if (inject != 0 && k == inject) begin
                bus8.start = 1'b1;
                bus8.a     = 8'hFF;
                bus8.b     = 8'hFF;
            end else begin
                bus8.start = 1'b0;
            end
            check($sformatf("done_e%0d", k), 32'(bus8.done), (k == 8) ? 32'd1 : 32'd0);
            check($sformatf("busy_e%0d", k), 32'(bus8.busy), 32'd1);
            if (k < 8) begin
                if (k == 4) begin
                    check("sum_held", 32'(bus8.sum), 32'(prev_sum));
                    check("cout_held", 32'(bus8.cout), 32'(prev_cout));
                end
            end else begin
                check("sum", 32'(bus8.sum), 32'(es));
                check("cout", 32'(bus8.cout), 32'(ec));
            end
        end
        @(negedge clk);                       // after E9: back in IDLE
        check("done_fall", 32'(bus8.done), 32'd0);
        check("busy_fall", 32'(bus8.busy), 32'd0);
        @(negedge clk);
        check("idle_stays", 32'(bus8.busy), 32'd0);
        $display("[TB] W8 a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d (exp %02h %0d)",
                 a, b, cin, bus8.sum, bus8.cout, es, ec);
        prev_sum  = es;
        prev_cout = ec;
    endtask

    task automatic run_op2(input logic [1:0] a, input logic [1:0] b, input logic cin);
        logic [2:0] expv;
        int         lat;
        expv = 3'(a) + 3'(b) + 3'(cin);
        lat  = 0;
        @(negedge clk);
        bus2.a     = a;
        bus2.b     = b;
        bus2.cin   = cin;
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clk);
            if (bus2.done) lat = k;
        end
        if (lat == 0) begin
            check("w2_done_timeout", 32'd0, 32'd1);
        end else begin
            check("w2_latency", 32'(lat), 32'd2);
            check("w2_result", 32'({bus2.cout, bus2.sum}), 32'(expv));
        end
        $display("[TB] W2 a=%0d b=%0d cin=%0d -> cout=%0d sum=%0d (exp %0d)",
                 a, b, cin, bus2.cout, bus2.sum, expv);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        prev_sum  = 8'h00;
        prev_cout = 1'b0;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0};
        vecs[2] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 0};
        vecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 0};
        vecs[4] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3};

        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus8.busy), 32'd0);
        check("rst_done", 32'(bus8.done), 32'd0);
        check("rst_sum", 32'(bus8.sum), 32'd0);
        check("rst_cout", 32'(bus8.cout), 32'd0);
        check("rst_w2_result", 32'({bus2.cout, bus2.sum}), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_op8(vecs[i].a, vecs[i].b, vecs[i].cin,
                    vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].inject);
        end

        // Abort after the 4th shift edge: outputs clear at once, no done follows.
        @(negedge clk);
        bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", 32'(bus8.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus8.busy), 32'd0);
        check("abort_done", 32'(bus8.done), 32'd0);
        check("abort_sum", 32'(bus8.sum), 32'd0);
        check("abort_cout", 32'(bus8.cout), 32'd0);
        prev_sum  = 8'h00;
        prev_cout = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            check("abort_no_done", 32'(bus8.done), 32'd0);
        end
        run_op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0);

        // WIDTH=2 exhaustive sweep over {a, b, cin}.
        for (int v = 0; v < 32; v++) begin
            logic [4:0] vv;
            vv = 5'(v);
            run_op2(vv[4:3], vv[2:1], vv[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder built around the team's half-adder cell: two half adders plus an OR form a full adder, and a carry flip-flop chains the bits across clock cycles. The block accepts two WIDTH-bit operands and a carry-in on a start strobe. It adds them LSB-first, one bit per clock, and presents the registered WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits directly downstream of the half-adder cell, as its sequential consumer, and is the first multi-bit arithmetic stage in the combinational-logic series.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range is WIDTH >= 2.
- clk  in  1  single system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepting edge.
- b  in  WIDTH  operand B; captured on the accepting edge.
- cin  in  1  carry-in; captured on the accepting edge.
- busy  out  1  high while an operation is in flight (SHIFT or DONE).
- done  out  1  one-cycle pulse; sum and cout are valid when it rises.
- sum  out  WIDTH  registered result; holds its value until the next completion.
- cout  out  1  registered carry-out of bit WIDTH-1.

## Operation
- Reset (rst_n low, asynchronous):
  - state goes to IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flop and bit counter clear.
  - Any in-flight operation is discarded; no done is issued for it.
- State machine has three states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at an edge, capture a, b and cin into the shift registers and carry flop.
  - Clear the bit counter and go to SHIFT.
  - If start=0, remain in IDLE.
- SHIFT, on each edge:
  - Half adder 1: s1 = a_sh[0] ^ b_sh[0], c1 = a_sh[0] & b_sh[0].
  - Half adder 2: s = s1 ^ carry, c2 = s1 & carry. Next carry = c1 | c2.
  - Shift s into the MSB of the result shift register; shift a_sh and b_sh right by one; increment the counter.
  - After the WIDTH-th shift edge, load the sum output from the result register, load cout from the final carry, and go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - On the next edge, go to IDLE.
- start is ignored in SHIFT and DONE, with no queuing. Operand changes after capture have no effect.
- sum and cout keep the previous result throughout an operation. They change only on the edge that enters DONE.
- Arithmetic is unsigned: {cout, sum} = a + b + cin, with no overflow flag.

## Timing
- Edge E0 is the edge that samples start=1 in IDLE. busy rises immediately after E0.
- Shift edges are E1 through E_WIDTH. sum and cout update at E_WIDTH, and done is high in the cycle from E_WIDTH to E_WIDTH+1.
- Latency from the accepting edge to done high is WIDTH clock edges.
- At E_WIDTH+1, done falls and busy falls; the state is IDLE.
- The earliest next accepting edge is E_WIDTH+2, giving a minimum issue interval of WIDTH+2 cycles.
- start held high continuously therefore restarts an operation every WIDTH+2 cycles. Each restart re-captures the current a, b and cin.
- rst_n asserted at any point, including during the done cycle, forces all outputs low within the same cycle.
- Operation resumes on the first rising clk edge after rst_n deasserts.

## Test plan
- Reset, then a=0x00, b=0x00, cin=0 with start for one cycle (WIDTH=8):
  - busy rises after the accepting edge.
  - done pulses exactly 8 edges after acceptance.
  - sum=0x00, cout=0.
- a=0xFF, b=0x01, cin=0: sum=0x00, cout=1. Then a=0x3C, b=0x42, cin=0: sum=0x7E, cout=0. Check that sum stays 0x00 throughout the second operation until its done edge.
- a=0xA5, b=0x5A, cin=1: sum=0x00, cout=1, showing carry propagating through all 8 bits.
- Start a=0x10, b=0x20, then pulse start with a=0xFF, b=0xFF while busy:
  - Exactly one done is issued.
  - Result is sum=0x30, cout=0; the second request is ignored.
- Start a=0x12, b=0x34, then drop rst_n after the 4th shift edge:
  - busy, done, sum and cout are all 0 immediately.
  - No done is issued for the aborted operation.
  - After release, a=0x12, b=0x34 gives sum=0x46.
- WIDTH=2 exhaustive sweep: drive {a, b, cin} over all 32 values, one operation each. Compare {cout, sum} against a+b+cin on every done pulse and log each result with $monitor-style output.
